// File: rtl/adc_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_scheduler
//  Purpose  : Issues periodic SYNC pulses to the ADC wrapper, gathers the
//             per-channel samples into one multi-channel frame, hands the
//             frame to a consumer over valid/ready, and flags timeout,
//             ordering, late-tick and overrun conditions as sticky errors.
//  Revision : 1.0  initial release
// ============================================================================
module adc_frame_scheduler #(
    parameter int NUM_CH  = 6,
    parameter int DW      = 16,
    parameter int PERIOD  = 1024,
    parameter int TIMEOUT = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 adc_op_mode,
    input  logic [DW-1:0]        adc_data,
    input  logic                 adc_rd_en,
    input  logic [2:0]           adc_channel,
    output logic                 sync_o,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [NUM_CH*DW-1:0] frame_data,
    output logic [7:0]           frame_seq,
    output logic                 busy,
    input  logic                 clear_err,
    output logic                 err_timeout,
    output logic                 err_order,
    output logic                 err_late,
    output logic                 err_overrun
);

    localparam int c_PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PERIOD - 1);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);
    localparam logic [3:0]      c_NCH  = 4'(NUM_CH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_COLLECT = 2'd2;
    localparam logic [1:0] c_ST_PUBLISH = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_PW-1:0]      r_pcnt;
    logic [c_TW-1:0]      r_tcnt;
    logic [NUM_CH-1:0]    r_mask;
    logic [NUM_CH-1:0]    w_mask_nxt;
    logic [NUM_CH-1:0]    w_ch_hit;
    logic [3:0]           r_exp;
    logic [NUM_CH*DW-1:0] r_buf;
    logic [7:0]           r_seq;
    logic                 r_sync;
    logic                 r_frame_valid;
    logic [NUM_CH*DW-1:0] r_frame_data;
    logic [7:0]           r_frame_seq;
    logic                 r_err_timeout;
    logic                 r_err_order;
    logic                 r_err_late;
    logic                 r_err_overrun;

    logic w_tick;
    logic w_collect;
    logic w_publish;
    logic w_start;
    logic w_rd_col;
    logic w_ch_ok;
    logic w_bad;
    logic w_done;
    logic w_tout;
    logic w_slot_free;
    logic w_ev_order;
    logic w_ev_late;
    logic w_ev_overrun;

    assign w_tick      = adc_op_mode && (r_pcnt == c_PMAX);
    assign w_collect   = (r_state == c_ST_COLLECT);
    assign w_publish   = (r_state == c_ST_PUBLISH);
    assign w_start     = (r_state == c_ST_WAIT) && w_tick && enable;
    assign w_rd_col    = w_collect && adc_rd_en;
    assign w_ch_ok     = ({1'b0, adc_channel} < c_NCH);
    // Any deviation from the strict 0,1,2,... sequence counts as an ordering fault
    assign w_bad       = !w_ch_ok || ({1'b0, adc_channel} != r_exp) || (|(w_ch_hit & r_mask));
    assign w_mask_nxt  = r_mask | (w_rd_col ? w_ch_hit : '0);
    // Completion looks at the mask including this cycle's sample so the frame
    // moves to PUBLISH on the cycle right after the last channel arrives
    assign w_done      = &w_mask_nxt;
    assign w_tout      = w_collect && adc_op_mode && (r_tcnt == c_TMAX) && !w_done;
    assign w_slot_free = !r_frame_valid || frame_ready;

    assign w_ev_order   = adc_rd_en && (!w_collect || w_bad);
    assign w_ev_late    = w_collect && w_tick;
    assign w_ev_overrun = w_publish && !w_slot_free;

    // One-hot decode of the incoming channel; empty for channels >= NUM_CH
    always_comb begin
        w_ch_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_hit[i] = (adc_channel == 3'(i));
        end
    end

    // Period counter: free-runs only while the ADC is in data mode
    always_ff @(posedge clk) begin
        if (rst || !adc_op_mode) begin
            r_pcnt <= '0;
        end else if (r_pcnt == c_PMAX) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + c_PW'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (adc_op_mode) w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (!adc_op_mode)  w_state_nxt = c_ST_IDLE;
                else if (w_start)  w_state_nxt = c_ST_COLLECT;
            end
            c_ST_COLLECT: begin
                if (!adc_op_mode)  w_state_nxt = c_ST_IDLE;
                else if (w_done)   w_state_nxt = c_ST_PUBLISH;
                else if (w_tout)   w_state_nxt = c_ST_WAIT;
            end
            c_ST_PUBLISH: begin
                w_state_nxt = c_ST_WAIT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // SYNC pulse coincides with the first COLLECT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 1'b0;
        end else begin
            r_sync <= w_start;
        end
    end

    // Per-frame bookkeeping: timeout counter, capture mask, expected channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_mask <= '0;
            r_exp  <= '0;
        end else if (w_start) begin
            r_tcnt <= '0;
            r_mask <= '0;
            r_exp  <= '0;
        end else if (w_collect) begin
            r_tcnt <= r_tcnt + c_TW'(1);
            r_mask <= w_mask_nxt;
            if (adc_rd_en && (r_exp != 4'hF)) begin
                r_exp <= r_exp + 4'd1;
            end
        end
    end

    // Sample slots; a duplicate channel simply overwrites the older sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_rd_col && w_ch_hit[i]) begin
                    r_buf[i*DW +: DW] <= adc_data;
                end
            end
        end
    end

    // Output slot and sequence numbering; a dropped frame still consumes a number
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_seq   <= '0;
        end else if (w_publish) begin
            r_seq <= r_seq + 8'd1;
            if (w_slot_free) begin
                r_frame_valid <= 1'b1;
                r_frame_data  <= r_buf;
                r_frame_seq   <= r_seq;
            end
        end else if (r_frame_valid && frame_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

    // Sticky error flags; a fresh event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_timeout <= 1'b0;
            r_err_order   <= 1'b0;
            r_err_late    <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_timeout <= w_tout       ? 1'b1 : (clear_err ? 1'b0 : r_err_timeout);
            r_err_order   <= w_ev_order   ? 1'b1 : (clear_err ? 1'b0 : r_err_order);
            r_err_late    <= w_ev_late    ? 1'b1 : (clear_err ? 1'b0 : r_err_late);
            r_err_overrun <= w_ev_overrun ? 1'b1 : (clear_err ? 1'b0 : r_err_overrun);
        end
    end

    assign sync_o      = r_sync;
    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
    assign frame_seq   = r_frame_seq;
    assign busy        = w_collect;
    assign err_timeout = r_err_timeout;
    assign err_order   = r_err_order;
    assign err_late    = r_err_late;
    assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire

// File: doc/adc_frame_scheduler.md
Name: adc_frame_scheduler

Overview:
Sampling scheduler sitting in the clk domain next to the ADC wrapper. Issues periodic SYNC pulses once the ADC reports data mode. Gathers the per-channel samples returned on DATA_O/RD_EN/CHANNEL into one multi-channel frame and hands each frame to a consumer over a valid/ready handshake. Detects missing, out-of-order, late and dropped frames and reports them through sticky error flags.

Parameters:
NUM_CH, 6, channels per frame (1..8)
DW, 16, sample width
PERIOD, 1024, clk cycles between SYNC pulses (>= TIMEOUT+2)
TIMEOUT, 512, max clk cycles from SYNC to last channel before the frame is abandoned

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  allow new SYNC pulses
adc_op_mode  in  1  ADC in data mode (wrapper OP_MODE)
adc_data  in  DW  sample (wrapper DATA_O)
adc_rd_en  in  1  one-cycle new-sample strobe (wrapper RD_EN)
adc_channel  in  3  channel of adc_data
sync_o  out  1  one-cycle capture command to wrapper SYNC
frame_valid  out  1  frame_data holds an unconsumed frame
frame_ready  in  1  consumer accepts frame
frame_data  out  NUM_CH*DW  channel k at bits [k*DW +: DW]
frame_seq  out  8  sequence number of the frame on frame_data
busy  out  1  state is COLLECT
clear_err  in  1  clears all sticky error flags
err_timeout  out  1  sticky: frame abandoned on timeout
err_order  out  1  sticky: channel out of order, duplicated or >= NUM_CH
err_late  out  1  sticky: period tick while still collecting
err_overrun  out  1  sticky: complete frame dropped because the output slot was full

Behaviour:
- Reset (rst=1 on a clk edge): state IDLE, counters 0, capture mask 0. sync_o=0, frame_valid=0, frame_data=0, frame_seq=0, busy=0, all err_* = 0.
- Period counter pcnt counts 0..PERIOD-1 and wraps. It runs only while adc_op_mode=1. It is forced to 0 whenever adc_op_mode=0. Tick = cycle with pcnt==PERIOD-1.
- States:
  - IDLE: go to WAIT when adc_op_mode=1.
  - WAIT:
    - adc_op_mode=0 -> IDLE.
    - On tick with enable=1 -> sync_o=1 for exactly that cycle; clear mask and tcnt; go to COLLECT.
    - Tick with enable=0 -> no pulse.
    - First SYNC therefore appears PERIOD cycles after adc_op_mode rises.
  - COLLECT, on each adc_rd_en:
    - Store adc_data at slot adc_channel and set mask bit.
    - Expected channel is a counter starting at 0. Mismatch, a channel >= NUM_CH, or an already-set mask bit -> err_order=1.
    - Invalid channel (>= NUM_CH): data discarded.
    - Duplicate: newer data overwrites.
  - COLLECT, completion: when all NUM_CH mask bits are set, go to PUBLISH next cycle.
  - COLLECT, timeout: tcnt increments each cycle. tcnt==TIMEOUT-1 without completion -> err_timeout=1, frame discarded, go to WAIT.
  - COLLECT, late tick: tick while in COLLECT -> no sync_o, err_late=1.
  - COLLECT, mode loss: adc_op_mode=0 -> discard frame, go to IDLE with no error.
  - enable falling during COLLECT does not abort; the frame completes or times out.
  - PUBLISH (one cycle):
    - Slot free (frame_valid=0, or frame_valid&frame_ready in this cycle) -> load frame_data and frame_seq=seq, seq+=1 (wraps 255->0), frame_valid=1 next cycle.
    - Slot busy -> frame dropped, err_overrun=1, seq still increments.
    - Go to WAIT.
- Latency: frame_valid rises 2 cycles after the adc_rd_en of the last channel.
- Handshake: frame_valid & frame_ready -> frame_valid drops next cycle unless PUBLISH reloads in the same cycle. frame_data and frame_seq stay stable while frame_valid=1 and not accepted.
- rd_en outside COLLECT: ignored, err_order=1.
- Sticky errors: clear_err=1 clears all err_* in that cycle. A new error event in the same cycle takes priority and sets its flag.
- busy = (state==COLLECT).

Test Plan:
Bench uses NUM_CH=6, PERIOD=64, TIMEOUT=40.
1. Nominal: rst, then adc_op_mode=1 and enable=1 -> sync_o pulse at cycle 64 after mode rise. Feed ch0..5 with data 16'h1000+ch at 3-cycle spacing, frame_ready=1 -> frame_valid 2 cycles after ch5; frame_data slot k = 16'h1000+k; frame_seq=0. Next SYNC 64 cycles after the first.
2. Back-pressure: frame_ready=0 across two periods -> first frame held stable, second dropped, err_overrun=1, held frame_seq=0. Then frame_ready=1 -> accepted, and the next published frame has frame_seq=2.
3. Timeout: after SYNC feed only ch0..3 -> err_timeout=1 at 40 cycles after SYNC, no frame_valid. Next SYNC still occurs on schedule.
4. Order/late: feed ch0,ch2,ch1,... -> err_order=1. Hold the frame beyond PERIOD with TIMEOUT raised to 70 -> err_late=1 and no sync_o at that tick. clear_err=1 -> all flags return to 0.
5. Mode loss/reset: drop adc_op_mode mid-COLLECT -> IDLE, no frame, no error. Assert rst mid-COLLECT -> all outputs at reset values the next cycle. Next SYNC only 64 cycles after mode re-rises.
6. enable=0 -> no sync_o for 3 periods. Re-enable -> SYNC on the next tick; frame_seq continues from its previous value.
